// File: rtl/triage_dispatcher.sv
// Patient triage dispatcher: pulls patients off the priority queue and
// assigns each one to the lowest-numbered idle doctor, timing the consults.
module triage_dispatcher #(
    parameter int NUM_DOC   = 2,
    parameter int TIME_UNIT = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_empty,
    input  logic                   q_valid,
    input  logic [3:0]             q_data,
    input  logic                   pause,
    output logic                   deq_req,
    output logic [NUM_DOC-1:0]     doc_busy,
    output logic [2*NUM_DOC-1:0]   doc_pid,
    output logic                   assign_valid,
    output logic [1:0]             assign_doc,
    output logic [3:0]             assign_word,
    output logic [7:0]             served_cnt,
    output logic                   timeout_err,
    output logic                   protocol_err
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t                     state;
    state_t                     state_d;
    logic [WW-1:0]              wait_cnt;
    logic [NUM_DOC-1:0][7:0]    timer;
    logic                       all_busy;
    logic                       do_assign;
    logic                       tmo_hit;
    logic                       proto_hit;
    logic [1:0]                 free_idx;
    logic [7:0]                 load;

    always_comb begin
        free_idx = 2'd0;
        for (int k = NUM_DOC - 1; k >= 0; k--) begin
            if (!doc_busy[k]) free_idx = 2'(k);
        end
    end

    assign all_busy  = &doc_busy;
    assign load      = ({6'd0, q_data[3:2]} + 8'd1) * 8'(TIME_UNIT);
    assign do_assign = (state == WAIT) && q_valid && !all_busy;
    assign tmo_hit   = (state == WAIT) && !q_valid && (wait_cnt == TMO_LAST);
    assign proto_hit = q_valid && (state != WAIT);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (!pause && !q_empty && !all_busy) state_d = REQ;
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (q_valid || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            deq_req      <= 1'b0;
            assign_valid <= 1'b0;
            assign_doc   <= 2'd0;
            assign_word  <= 4'd0;
            served_cnt   <= 8'd0;
            timeout_err  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_d;
            wait_cnt     <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            deq_req      <= (state_d == REQ);
            assign_valid <= do_assign;
            if (do_assign) begin
                assign_doc  <= free_idx;
                assign_word <= q_data;
                if (served_cnt != 8'hFF) served_cnt <= served_cnt + 8'd1;
            end
            if (tmo_hit)   timeout_err  <= 1'b1;
            if (proto_hit) protocol_err <= 1'b1;
        end
    end

    // A newly assigned doctor wins over its own timer expiring.
    always_ff @(posedge clk) begin
        if (rst) begin
            doc_busy <= '0;
            doc_pid  <= '0;
            timer    <= '0;
        end else begin
            for (int k = 0; k < NUM_DOC; k++) begin
                if (do_assign && free_idx == 2'(k)) begin
                    doc_busy[k]         <= 1'b1;
                    timer[k]            <= load;
                    doc_pid[2*k +: 2]   <= q_data[1:0];
                end else if (doc_busy[k]) begin
                    timer[k] <= timer[k] - 8'd1;
                    if (timer[k] == 8'd1) doc_busy[k] <= 1'b0;
                end
            end
        end
    end

endmodule
